// File: rtl/sincos_pkg.sv
// Shared widths, FSM encoding, load-mode constants and saturating negate for the sin/cos table loader.
package sincos_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2**ADDR_W;

  localparam logic MODE_FULL   = 1'b0;
  localparam logic MODE_MIRROR = 1'b1;

  typedef enum logic [1:0] {IDLE, LOAD, MIR, DONE} state_t;

  // Two's-complement negate; the most negative code clips to the most positive.
  function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
    return DATA_W'(0) - x;
  endfunction

endpackage

// File: rtl/sat_negate.sv
// Combinational saturating negate: -x, with the most negative input clipped to the most positive.
module sat_negate #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  assign y = (x == MOST_NEG) ? MOST_POS : (~x + DATA_W'(1));

endmodule

// File: rtl/sincos_table_loader.sv
// Streams host sin/cos pairs into table port 0, optionally mirroring the negated half-wave; write
// appears the cycle after accept, s_ready drops in MIR so mirror loads take one pair per two cycles.
module sincos_table_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_sin,
  input  logic [DATA_W-1:0] s_cos,
  output logic              csb0,
  output logic              web0,
  output logic [3:0]        wmask0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din00,
  output logic [DATA_W-1:0] din01,
  output logic              csb1,
  output logic              busy,
  output logic              done
);

  import sincos_pkg::*;

  localparam logic [ADDR_W-1:0] HALF = {1'b1, {(ADDR_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                mode_q, mode_d;
  logic                wr_d, busy_d, done_d, csb1_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   sin_d, cos_d;
  logic [DATA_W-1:0]   neg_sin, neg_cos;

  // The mirror write negates the data registers still holding the pair just written.
  sat_negate #(.DATA_W(DATA_W)) u_neg_sin (.x(din00), .y(neg_sin));
  sat_negate #(.DATA_W(DATA_W)) u_neg_cos (.x(din01), .y(neg_cos));

  assign s_ready = (state_q == LOAD);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    wr_d    = 1'b0;
    addr_d  = addr0;
    sin_d   = din00;
    cos_d   = din01;
    busy_d  = 1'b0;
    done_d  = done;
    csb1_d  = csb1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          mode_d  = mode;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          csb1_d  = 1'b1;
        end
      end
      LOAD: begin
        busy_d = 1'b1;
        if (s_valid) begin
          wr_d   = 1'b1;
          addr_d = idx_q;
          sin_d  = s_sin;
          cos_d  = s_cos;
          idx_d  = idx_q + ADDR_W'(1);
          if (mode_q == MODE_MIRROR) state_d = MIR;
          else if (idx_q == LAST)    state_d = DONE;
        end
      end
      MIR: begin
        busy_d  = 1'b1;
        wr_d    = 1'b1;
        addr_d  = addr0 + HALF;
        sin_d   = neg_sin;
        cos_d   = neg_cos;
        state_d = (idx_q == HALF) ? DONE : LOAD;
      end
      DONE: begin
        // Entered while the final write is still on the port; the read side opens a cycle later.
        done_d = 1'b1;
        csb1_d = 1'b0;
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          mode_d  = mode;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          csb1_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= MODE_FULL;
      csb0    <= 1'b1;
      web0    <= 1'b1;
      wmask0  <= 4'h0;
      addr0   <= '0;
      din00   <= '0;
      din01   <= '0;
      csb1    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      csb0    <= ~wr_d;
      web0    <= ~wr_d;
      wmask0  <= wr_d ? 4'hF : 4'h0;
      addr0   <= addr_d;
      din00   <= sin_d;
      din01   <= cos_d;
      csb1    <= csb1_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_sincos_table_loader.sv
// Scoreboard bench: the driver queues each expected table write as a pair is accepted; a monitor pops on every port-0 write.
module tb_sincos_table_loader;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int N  = 512;
  localparam int H  = 256;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_sin = '0;
  logic [DW-1:0] s_cos = '0;
  logic          csb0, web0, csb1, busy, done;
  logic [3:0]    wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din00, din01;

  always #5 clk = ~clk;

  sincos_table_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_sin(s_sin), .s_cos(s_cos),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din00(din00), .din01(din01), .csb1(csb1), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] s;
    logic [DW-1:0] c;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] fsin[N], fcos[N], msin[H], mcos[H], tsin[N], tcos[N];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_wr  = 0;

  function automatic logic [DW-1:0] neg_exp(input logic [DW-1:0] x);
    if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
    return 32'd0 - x;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'(0));
    check({tag, "_csb0"},    64'(csb0),    64'(1));
    check({tag, "_web0"},    64'(web0),    64'(1));
    check({tag, "_wmask0"},  64'(wmask0),  64'(0));
    check({tag, "_addr0"},   64'(addr0),   64'(0));
    check({tag, "_din00"},   64'(din00),   64'(0));
    check({tag, "_din01"},   64'(din01),   64'(0));
    check({tag, "_csb1"},    64'(csb1),    64'(1));
    check({tag, "_busy"},    64'(busy),    64'(0));
    check({tag, "_done"},    64'(done),    64'(0));
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) begin
      tsin[i] = 32'hDEAD_BEEF;
      tcos[i] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic compare_table(input bit m, input string nm);
    int bad = 0;
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] es, ec;
      if (!m) begin
        es = fsin[i]; ec = fcos[i];
      end else if (i < H) begin
        es = msin[i]; ec = mcos[i];
      end else begin
        es = neg_exp(msin[i-H]); ec = neg_exp(mcos[i-H]);
      end
      if (tsin[i] !== es || tcos[i] !== ec) bad++;
    end
    check(nm, 64'(bad), 64'(0));
  endtask

  // Called at a negedge; returns at the negedge after the last accept with k = negedges since start.
  task automatic run_load(input logic m, input int n, input int stall, input int ign_at, output int k);
    int i = 0;
    bit prev = 1'b0;
    bit acc;
    k = 0;
    start = 1'b1;
    mode  = m;
    @(negedge clk); k++;
    start = 1'b0;
    mode  = ~m;
    check("start_s_ready", 64'(s_ready), 64'(1));
    check("start_busy",    64'(busy),    64'(1));
    check("start_done",    64'(done),    64'(0));
    check("start_csb1",    64'(csb1),    64'(1));
    while (i < n && k < 20000) begin
      start   = (i == ign_at);
      s_valid = ($urandom_range(99) >= stall);
      s_sin   = m ? msin[i % H] : fsin[i];
      s_cos   = m ? mcos[i % H] : fcos[i];
      if (m) check("mirror_s_ready", 64'(s_ready), prev ? 64'(0) : 64'(1));
      acc = s_valid && s_ready;
      if (acc) begin
        exp_q.push_back('{a: AW'(i), s: s_sin, c: s_cos});
        if (m) exp_q.push_back('{a: AW'(i + H), s: neg_exp(s_sin), c: neg_exp(s_cos)});
        i++;
      end
      prev = acc;
      @(negedge clk); k++;
    end
    start   = 1'b0;
    s_valid = 1'b0;
    if (i < n) check("load_timeout_beats", 64'(i), 64'(n));
  endtask

  task automatic wait_done(inout int k, input int lim);
    while (done !== 1'b1 && k < lim) begin
      @(negedge clk); k++;
    end
    check("done_reached", 64'(done), 64'(1));
    check("done_csb1",    64'(csb1), 64'(0));
  endtask

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (csb0 === 1'b0) begin
        n_wr++;
        tsin[addr0] = din00;
        tcos[addr0] = din01;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got write at addr %0d, want no write", addr0);
        end else begin
          e = exp_q.pop_front();
          if (addr0 !== e.a || din00 !== e.s || din01 !== e.c || web0 !== 1'b0 || wmask0 !== 4'hF) begin
            n_bad++;
            $display("FAIL write: got a=%0d s=%h c=%h web0=%b wmask0=%h, want a=%0d s=%h c=%h web0=0 wmask0=f",
                     addr0, din00, din01, web0, wmask0, e.a, e.s, e.c);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of test, want finish before 1ms");
    $fatal(1);
  end

  initial begin : main
    int  k;
    real ph;
    for (int i = 0; i < N; i++) begin
      ph = 3.14159265358979 * i / 256.0;
      fsin[i] = $rtoi($sin(ph) * 2147483647.0);
      fcos[i] = $rtoi($cos(ph) * 2147483647.0);
    end
    for (int i = 0; i < H; i++) begin
      msin[i] = fsin[i];
      mcos[i] = fcos[i];
    end
    msin[5] = 32'h8000_0000;
    mcos[7] = 32'h8000_0000;
    clear_table();

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Full load, s_valid held high, with an ignored start mid-load.
    n_wr = 0;
    run_load(1'b0, N, 0, 50, k);
    while (k < 513) begin @(negedge clk); k++; end
    check("full_final_write", 64'({csb0, addr0}), 64'({1'b0, 9'd511}));
    check("full_done_513",    64'(done), 64'(0));
    @(negedge clk); k++;
    check("full_done_514",    64'(done),    64'(1));
    check("full_csb1_514",    64'(csb1),    64'(0));
    check("full_busy_514",    64'(busy),    64'(0));
    check("full_s_ready_514", 64'(s_ready), 64'(0));
    check("full_write_count", 64'(n_wr),    64'(N));
    check("full_queue_empty", 64'(exp_q.size()), 64'(0));
    compare_table(1'b0, "full_table");

    // Restart from DONE with host backpressure.
    repeat (3) @(negedge clk);
    clear_table();
    n_wr = 0;
    run_load(1'b0, N, 50, -1, k);
    wait_done(k, k + 20);
    check("bp_write_count", 64'(n_wr), 64'(N));
    compare_table(1'b0, "bp_table");

    // Reset in the middle of a load.
    run_load(1'b0, 100, 0, -1, k);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_reset("midrst");
    check("midrst_queue_empty", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    check("idle_s_ready", 64'(s_ready), 64'(0));
    check("idle_csb0",    64'(csb0),    64'(1));

    // Mirror load from IDLE, including saturating values.
    clear_table();
    n_wr = 0;
    run_load(1'b1, H, 0, -1, k);
    wait_done(k, k + 20);
    check("mir_write_count", 64'(n_wr), 64'(N));
    check("mir_queue_empty", 64'(exp_q.size()), 64'(0));
    compare_table(1'b1, "mir_table");
    check("mir_sat_sin", 64'(tsin[261]), 64'(32'h7FFF_FFFF));
    check("mir_sat_cos", 64'(tcos[263]), 64'(32'h7FFF_FFFF));
    check("mir_raw_sin", 64'(tsin[5]),   64'(32'h8000_0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sincos_table_loader.md
# sincos_table_loader

Loads the 512-entry sine/cosine lookup table that the phase counter reads. The block accepts (sine, cosine) sample pairs from a host stream over a valid/ready handshake and drives the table's write port (port 0). When the load is complete, it enables the counter's read port (port 1). In mirror mode it takes only the first half-wave (256 pairs) and writes the second half itself as the negated copy. This halves host traffic.

## Interface
Parameters:
- ADDR_W, 9, table address width; DEPTH = 2**ADDR_W
- DATA_W, 32, sample width, signed Q1.31

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load; sampled only in IDLE or DONE
- mode  in  1  sampled with start: 0 = full (DEPTH pairs), 1 = mirror (DEPTH/2 pairs)
- s_valid  in  1  host sample pair valid
- s_ready  out  1  loader accepts pair this cycle
- s_sin  in  DATA_W  sine sample
- s_cos  in  DATA_W  cosine sample
- csb0  out  1  table port-0 select, active-low
- web0  out  1  table port-0 write enable, active-low
- wmask0  out  4  write mask; 4'hF on every write, 4'h0 otherwise
- addr0  out  ADDR_W  write address
- din00  out  DATA_W  sine write data
- din01  out  DATA_W  cosine write data
- csb1  out  1  table port-1 (counter read) select, active-low; 0 only when the table is valid
- busy  out  1  load in progress
- done  out  1  table loaded; held until next start

## Operation
- States:
  - IDLE: after reset; s_ready=0.
  - LOAD: s_ready=1. Accepts a pair when s_valid&&s_ready.
  - MIR: mirror second write; s_ready=0; lasts exactly 1 cycle.
  - DONE: s_ready=0.
- IDLE/DONE -> LOAD on start. The beat index idx is cleared, the mode is latched, done=0, csb1=1, busy=1.
- Write for each accepted beat: csb0=0, web0=0, wmask0=4'hF, addr0=idx, din00=s_sin, din01=s_cos. Then idx+1.
- Mirror mode, after each accept: go to MIR. MIR writes addr0=idx+DEPTH/2, din00=sat_neg(s_sin), din01=sat_neg(s_cos), then returns to LOAD.
- sat_neg(x): two's-complement negate; -2**(DATA_W-1) maps to 2**(DATA_W-1)-1.
- Last beat:
  - Full mode: idx=DEPTH-1.
  - Mirror mode: idx=DEPTH/2-1, and its MIR write completes the load.
  - After the final write, go to DONE: busy=0, done=1, csb1=0.
- No write cycle: csb0=1, web0=1, wmask0=0. addr0 and din hold their last values.
- start in LOAD or MIR is ignored.
- start in DONE: csb1 returns to 1 in the next cycle, and the table is rewritten from idx 0.
- s_valid low in LOAD: the loader stalls indefinitely with no write and no timeout.
- reset_n low in any state, including mid-load: next cycle is IDLE with all outputs at reset values. The partially written table is treated as invalid (csb1=1).

## Timing
- Reset values: s_ready=0, csb0=1, web0=1, wmask0=0, addr0=0, din00=0, din01=0, csb1=1, busy=0, done=0.
- All outputs are registered except s_ready, which is decoded from the state register.
- Beat accepted at edge t: its write is presented in cycle t+1. The table captures it at edge t+2.
- Mirror write is presented in cycle t+2. The next accept is possible at edge t+2, so mirror throughput is 1 pair per 2 cycles.
- Full mode, s_valid held high: 1 pair/cycle. The final write is at cycle start+DEPTH+1.
- Both modes: done=1 and csb1=0 in the cycle after the final write. The write and the first read therefore never overlap.
- start to s_ready=1: 1 cycle.

## Structure
- Shared package `sincos_pkg`: ADDR_W, DATA_W, DEPTH, state enum {IDLE, LOAD, MIR, DONE}, MODE_FULL/MODE_MIRROR constants, and the sat_neg function.
- One sub-module, `sat_negate`: parameterised DATA_W, combinational saturating negate, instanced twice (sine, cosine).
- The write-port register bank and the FSM live in the top module.

## Test plan
- Full load: start, mode=0, 512 pairs (sin(pi*i/256)*(2**31-1), cos(...)) with s_valid high. Required: 512 writes at addr 0..511, data matching, done=1 and csb1=0 on cycle 514 after start.
- Mirror load: mode=0→1, 256 pairs. Required: addr i gets (s,c) and addr i+256 gets (-s,-c); s_ready toggles 1,0; done after 512 writes. Also s_sin=32'h8000_0000 must be written as 32'h7FFF_FFFF at addr+256.
- Backpressure: s_valid randomly dropped 50%. Required: no writes in stall cycles (csb0=1), final table identical to the no-stall case.
- Reset mid-load: reset_n low for 1 cycle after 100 beats. Required: all outputs at reset values, csb1=1, state IDLE. A subsequent start reloads from addr 0.
- Reload and ignored start: start pulsed during LOAD has no effect. Start in DONE forces csb1=1 next cycle, and a second full load completes with done reasserted.
